// File: rtl/arp_eth_rx_fifo.sv
// ARP receiver: collects the 28-byte ARP body from an Ethernet payload stream,
// classifies each frame at tlast and queues good frames in a fall-through FIFO.
module arp_eth_rx_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter bit KEEP_ENABLE   = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 4,
    parameter bit CHECK_TYPES   = 1,
    parameter bit FILTER_ENABLE = 0,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_eth_hdr_valid,
    output logic                   s_eth_hdr_ready,
    input  logic [47:0]            s_eth_dest_mac,
    input  logic [47:0]            s_eth_src_mac,
    input  logic [15:0]            s_eth_type,
    input  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_eth_payload_axis_tkeep,
    input  logic                   s_eth_payload_axis_tvalid,
    output logic                   s_eth_payload_axis_tready,
    input  logic                   s_eth_payload_axis_tlast,
    input  logic                   s_eth_payload_axis_tuser,
    input  logic [31:0]            local_ip,
    output logic                   m_frame_valid,
    input  logic                   m_frame_ready,
    output logic [47:0]            m_eth_dest_mac,
    output logic [47:0]            m_eth_src_mac,
    output logic [15:0]            m_eth_type,
    output logic [15:0]            m_arp_htype,
    output logic [15:0]            m_arp_ptype,
    output logic [15:0]            m_arp_oper,
    output logic [7:0]             m_arp_hlen,
    output logic [7:0]             m_arp_plen,
    output logic [47:0]            m_arp_sha,
    output logic [47:0]            m_arp_tha,
    output logic [31:0]            m_arp_spa,
    output logic [31:0]            m_arp_tpa,
    output logic                   busy,
    output logic                   error_header_early_termination,
    output logic                   error_invalid_header,
    output logic [COUNT_WIDTH-1:0] stat_rx_good,
    output logic [COUNT_WIDTH-1:0] stat_rx_drop,
    output logic [COUNT_WIDTH-1:0] stat_rx_filtered
);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("arp_eth_rx_fifo: DATA_WIDTH must be a multiple of 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("arp_eth_rx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int LAST_BEAT = 27 / KEEP_WIDTH;
    localparam int LAST_LANE = 27 % KEEP_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR, DRAIN} state_t;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } entry_t;

    state_t          state, state_next;
    logic [4:0]      beat_cnt;
    logic            got_all, got_all_now, last_hit;
    logic [7:0]      body [28];
    logic [7:0]      nb [28];
    logic [47:0]     dest_q, src_q;
    logic [15:0]     type_q;
    logic [KEEP_WIDTH-1:0] keep;
    logic            unused_keep;
    logic            hdr_fire, beat_fire, frame_end, hdr_ok, ip_miss;
    logic            ev_early, ev_invalid, ev_drop, ev_filtered, push, pop;
    entry_t          cur;
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_next;

    assign keep        = KEEP_ENABLE ? s_eth_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign unused_keep = ^s_eth_payload_axis_tkeep;
    assign hdr_fire    = (state == IDLE) && s_eth_hdr_valid && s_eth_hdr_ready;
    assign beat_fire   = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign frame_end   = beat_fire && s_eth_payload_axis_tlast && (state != IDLE);

    // Merge the current beat into the body so a tlast on the final ARP beat classifies complete data.
    always_comb begin
        nb       = body;
        last_hit = 1'b0;
        if (state == HDR && beat_fire) begin
            for (int k = 0; k < 28; k++) begin
                if (beat_cnt == 5'(k / KEEP_WIDTH) && keep[k % KEEP_WIDTH])
                    nb[k] = s_eth_payload_axis_tdata[(k % KEEP_WIDTH)*8 +: 8];
            end
            last_hit = (beat_cnt == 5'(LAST_BEAT)) && keep[LAST_LANE];
        end
        got_all_now = got_all || last_hit;
    end

    always_comb begin
        cur.dest_mac = dest_q;
        cur.src_mac  = src_q;
        cur.eth_type = type_q;
        cur.htype    = {nb[0], nb[1]};
        cur.ptype    = {nb[2], nb[3]};
        cur.hlen     = nb[4];
        cur.plen     = nb[5];
        cur.oper     = {nb[6], nb[7]};
        cur.sha      = {nb[8], nb[9], nb[10], nb[11], nb[12], nb[13]};
        cur.spa      = {nb[14], nb[15], nb[16], nb[17]};
        cur.tha      = {nb[18], nb[19], nb[20], nb[21], nb[22], nb[23]};
        cur.tpa      = {nb[24], nb[25], nb[26], nb[27]};
    end

    always_comb begin
        hdr_ok = (cur.hlen == 8'd6) && (cur.plen == 8'd4);
        if (CHECK_TYPES)
            hdr_ok = hdr_ok && (type_q == 16'h0806) && (cur.htype == 16'h0001) &&
                     (cur.ptype == 16'h0800) && (cur.oper == 16'd1 || cur.oper == 16'd2);
        ip_miss     = FILTER_ENABLE && (cur.tpa != local_ip);
        ev_early    = frame_end && !got_all_now;
        ev_invalid  = frame_end && got_all_now && !hdr_ok;
        ev_drop     = ev_early || ev_invalid || (frame_end && got_all_now && hdr_ok && s_eth_payload_axis_tuser);
        ev_filtered = frame_end && got_all_now && hdr_ok && !s_eth_payload_axis_tuser && ip_miss;
        push        = frame_end && got_all_now && hdr_ok && !s_eth_payload_axis_tuser && !ip_miss &&
                      (count != (AW+1)'(FIFO_DEPTH) || pop);
        pop         = (count != '0) && m_frame_ready;
        count_next  = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hdr_fire) state_next = HDR;
            HDR:     if (beat_fire) begin
                         if (s_eth_payload_axis_tlast)          state_next = IDLE;
                         else if (beat_cnt == 5'(LAST_BEAT))    state_next = DRAIN;
                     end
            DRAIN:   if (beat_fire && s_eth_payload_axis_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    // Header ready uses the post-push occupancy, so every accepted header owns a free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                          <= IDLE;
            s_eth_hdr_ready                <= 1'b0;
            s_eth_payload_axis_tready      <= 1'b0;
            busy                           <= 1'b0;
            error_header_early_termination <= 1'b0;
            error_invalid_header           <= 1'b0;
            stat_rx_good                   <= '0;
            stat_rx_drop                   <= '0;
            stat_rx_filtered               <= '0;
            beat_cnt                       <= '0;
            got_all                        <= 1'b0;
            wr_ptr                         <= '0;
            rd_ptr                         <= '0;
            count                          <= '0;
        end else begin
            state                          <= state_next;
            s_eth_hdr_ready                <= (state_next == IDLE) && (count_next < (AW+1)'(FIFO_DEPTH));
            s_eth_payload_axis_tready      <= (state_next != IDLE);
            busy                           <= (state_next == HDR);
            error_header_early_termination <= ev_early;
            error_invalid_header           <= ev_invalid;
            stat_rx_good                   <= sat_inc(stat_rx_good, push);
            stat_rx_drop                   <= sat_inc(stat_rx_drop, ev_drop);
            stat_rx_filtered               <= sat_inc(stat_rx_filtered, ev_filtered);
            if (hdr_fire) begin
                beat_cnt <= '0;
                got_all  <= 1'b0;
            end else if (state == HDR && beat_fire) begin
                beat_cnt <= beat_cnt + 5'd1;
                got_all  <= got_all_now;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_fire) begin
            dest_q <= s_eth_dest_mac;
            src_q  <= s_eth_src_mac;
            type_q <= s_eth_type;
        end
        if (state == HDR && beat_fire) body <= nb;
        if (push) mem[wr_ptr] <= cur;
    end

    assign m_frame_valid  = (count != '0);
    assign m_eth_dest_mac = mem[rd_ptr].dest_mac;
    assign m_eth_src_mac  = mem[rd_ptr].src_mac;
    assign m_eth_type     = mem[rd_ptr].eth_type;
    assign m_arp_htype    = mem[rd_ptr].htype;
    assign m_arp_ptype    = mem[rd_ptr].ptype;
    assign m_arp_hlen     = mem[rd_ptr].hlen;
    assign m_arp_plen     = mem[rd_ptr].plen;
    assign m_arp_oper     = mem[rd_ptr].oper;
    assign m_arp_sha      = mem[rd_ptr].sha;
    assign m_arp_spa      = mem[rd_ptr].spa;
    assign m_arp_tha      = mem[rd_ptr].tha;
    assign m_arp_tpa      = mem[rd_ptr].tpa;

endmodule

// File: tb/tb_arp_eth_rx_fifo.sv
// Bench for arp_eth_rx_fifo: an 8-bit instance with target-IP filtering and a
// 64-bit instance with 2-bit counters, both checked against a frame-level model.
module tb_arp_eth_rx_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        hdr_valid [2], hdr_ready [2];
    logic [47:0] dmac [2], smac [2];
    logic [15:0] etype [2];
    logic [63:0] tdata [2];
    logic [7:0]  tkeep [2];
    logic        tvalid [2], tready [2], tlast [2], tuser [2];
    logic [31:0] lip [2];
    logic        mvalid [2], mready [2], busy [2], e_early [2], e_inv [2];
    logic [47:0] o_dmac [2], o_smac [2], o_sha [2], o_tha [2];
    logic [15:0] o_etype [2], o_htype [2], o_ptype [2], o_oper [2];
    logic [7:0]  o_hlen [2], o_plen [2];
    logic [31:0] o_spa [2], o_tpa [2];
    logic [15:0] st_good [2], st_drop [2], st_filt [2];

    arp_eth_rx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FILTER_ENABLE(1)) dut8 (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(hdr_valid[0]), .s_eth_hdr_ready(hdr_ready[0]),
        .s_eth_dest_mac(dmac[0]), .s_eth_src_mac(smac[0]), .s_eth_type(etype[0]),
        .s_eth_payload_axis_tdata(tdata[0][7:0]), .s_eth_payload_axis_tkeep(tkeep[0][0:0]),
        .s_eth_payload_axis_tvalid(tvalid[0]), .s_eth_payload_axis_tready(tready[0]),
        .s_eth_payload_axis_tlast(tlast[0]), .s_eth_payload_axis_tuser(tuser[0]),
        .local_ip(lip[0]), .m_frame_valid(mvalid[0]), .m_frame_ready(mready[0]),
        .m_eth_dest_mac(o_dmac[0]), .m_eth_src_mac(o_smac[0]), .m_eth_type(o_etype[0]),
        .m_arp_htype(o_htype[0]), .m_arp_ptype(o_ptype[0]), .m_arp_oper(o_oper[0]),
        .m_arp_hlen(o_hlen[0]), .m_arp_plen(o_plen[0]), .m_arp_sha(o_sha[0]), .m_arp_tha(o_tha[0]),
        .m_arp_spa(o_spa[0]), .m_arp_tpa(o_tpa[0]), .busy(busy[0]),
        .error_header_early_termination(e_early[0]), .error_invalid_header(e_inv[0]),
        .stat_rx_good(st_good[0]), .stat_rx_drop(st_drop[0]), .stat_rx_filtered(st_filt[0])
    );

    arp_eth_rx_fifo #(.DATA_WIDTH(64), .FIFO_DEPTH(4), .COUNT_WIDTH(2)) dut64 (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(hdr_valid[1]), .s_eth_hdr_ready(hdr_ready[1]),
        .s_eth_dest_mac(dmac[1]), .s_eth_src_mac(smac[1]), .s_eth_type(etype[1]),
        .s_eth_payload_axis_tdata(tdata[1]), .s_eth_payload_axis_tkeep(tkeep[1]),
        .s_eth_payload_axis_tvalid(tvalid[1]), .s_eth_payload_axis_tready(tready[1]),
        .s_eth_payload_axis_tlast(tlast[1]), .s_eth_payload_axis_tuser(tuser[1]),
        .local_ip(lip[1]), .m_frame_valid(mvalid[1]), .m_frame_ready(mready[1]),
        .m_eth_dest_mac(o_dmac[1]), .m_eth_src_mac(o_smac[1]), .m_eth_type(o_etype[1]),
        .m_arp_htype(o_htype[1]), .m_arp_ptype(o_ptype[1]), .m_arp_oper(o_oper[1]),
        .m_arp_hlen(o_hlen[1]), .m_arp_plen(o_plen[1]), .m_arp_sha(o_sha[1]), .m_arp_tha(o_tha[1]),
        .m_arp_spa(o_spa[1]), .m_arp_tpa(o_tpa[1]), .busy(busy[1]),
        .error_header_early_termination(e_early[1]), .error_invalid_header(e_inv[1]),
        .stat_rx_good(st_good[1][1:0]), .stat_rx_drop(st_drop[1][1:0]), .stat_rx_filtered(st_filt[1][1:0])
    );

    int errors = 0;
    int checks = 0;

    logic [335:0] exp_q0 [$];
    logic [335:0] exp_q1 [$];
    int e_good [2], e_drop [2], e_filt [2], e_early_n [2], e_inv_n [2];
    int n_early [2], n_inv [2];

    logic [47:0] f_dmac, f_smac, f_sha, f_tha;
    logic [15:0] f_etype, f_htype, f_ptype, f_oper;
    logic [7:0]  f_hlen, f_plen;
    logic [31:0] f_spa, f_tpa;
    int          f_len;
    logic        f_user;
    logic [7:0]  pl [64];

    initial begin
        for (int s = 0; s < 2; s++) begin
            n_early[s] = 0;
            n_inv[s]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (e_early[s] === 1'b1) n_early[s]++;
            if (e_inv[s] === 1'b1)   n_inv[s]++;
        end
    end

    task automatic chk(input string tag, input logic [335:0] obs, input logic [335:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [335:0] out_vec(input int s);
        return {o_dmac[s], o_smac[s], o_etype[s], o_htype[s], o_ptype[s], o_hlen[s], o_plen[s],
                o_oper[s], o_sha[s], o_spa[s], o_tha[s], o_tpa[s]};
    endfunction

    function automatic int sat(input int s, input int v);
        int mx;
        mx = (s == 0) ? 65535 : 3;
        return (v > mx) ? mx : v;
    endfunction

    task automatic default_frame();
        f_dmac = 48'hFFFF_FFFF_FFFF;  f_smac = 48'h5A51_5253_5455;  f_etype = 16'h0806;
        f_htype = 16'h0001;  f_ptype = 16'h0800;  f_hlen = 8'd6;  f_plen = 8'd4;  f_oper = 16'd1;
        f_sha = 48'h5A51_5253_5455;  f_spa = 32'hC0A8_0164;  f_tha = 48'h0;  f_tpa = 32'hC0A8_0166;
        f_len = 28;  f_user = 1'b0;
    endtask

    task automatic build_payload();
        logic [223:0] arp;
        arp = {f_htype, f_ptype, f_hlen, f_plen, f_oper, f_sha, f_spa, f_tha, f_tpa};
        for (int i = 0; i < 64; i++)
            pl[i] = (i < 28) ? arp[223 - 8*i -: 8] : 8'($urandom);
    endtask

    task automatic send_frame(input int s, input int cut);
        int kw, nbeats, t, cls;
        logic [335:0] e;
        kw = (s == 0) ? 1 : 8;
        build_payload();
        e = {f_dmac, f_smac, f_etype, f_htype, f_ptype, f_hlen, f_plen, f_oper, f_sha, f_spa, f_tha, f_tpa};
        if (f_len < 28) cls = 1;
        else if (f_hlen != 8'd6 || f_plen != 8'd4 || f_etype != 16'h0806 || f_htype != 16'h0001 ||
                 f_ptype != 16'h0800 || (f_oper != 16'd1 && f_oper != 16'd2)) cls = 2;
        else if (f_user) cls = 3;
        else if (s == 0 && f_tpa != lip[0]) cls = 4;
        else cls = 5;
        dmac[s] = f_dmac;  smac[s] = f_smac;  etype[s] = f_etype;  hdr_valid[s] = 1'b1;
        t = 0;
        while (hdr_ready[s] !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
        chk("hdr_ready_wait", hdr_ready[s], 1);
        @(posedge clk); #1;
        hdr_valid[s] = 1'b0;
        chk("busy_in_hdr", busy[s], 1);
        nbeats = (f_len + kw - 1) / kw;
        for (int b = 0; b < nbeats; b++) begin
            if (cut > 0 && b == cut) break;
            tdata[s] = {$urandom, $urandom};
            tkeep[s] = 8'h00;
            for (int j = 0; j < kw; j++) begin
                if (b*kw + j < f_len) begin
                    tdata[s][j*8 +: 8] = pl[b*kw + j];
                    tkeep[s][j] = 1'b1;
                end
            end
            tlast[s]  = (b == nbeats - 1);
            tuser[s]  = (b == nbeats - 1) && f_user;
            tvalid[s] = 1'b1;
            t = 0;
            while (tready[s] !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
            chk("tready_wait", tready[s], 1);
            @(posedge clk); #1;
        end
        tvalid[s] = 1'b0;  tlast[s] = 1'b0;  tuser[s] = 1'b0;
        if (cut > 0) return;
        case (cls)
            1: begin e_early_n[s]++; e_drop[s]++; end
            2: begin e_inv_n[s]++;   e_drop[s]++; end
            3: e_drop[s]++;
            4: e_filt[s]++;
            default: begin
                e_good[s]++;
                if (s == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            end
        endcase
        chk("valid_after_tlast", mvalid[s], ((s == 0) ? exp_q0.size() : exp_q1.size()) != 0);
    endtask

    task automatic pop_check(input int s);
        logic [335:0] e;
        if (s == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        chk("m_valid", mvalid[s], 1);
        chk("m_entry", out_vec(s), e);
        mready[s] = 1'b1;
        @(posedge clk); #1;
        mready[s] = 1'b0;
    endtask

    task automatic drain(input int s);
        while (((s == 0) ? exp_q0.size() : exp_q1.size()) != 0) pop_check(s);
        chk("queue_empty", mvalid[s], 0);
    endtask

    task automatic check_stats(input int s);
        logic [15:0] cm;
        cm = (s == 0) ? 16'hFFFF : 16'h0003;
        repeat (2) @(posedge clk);
        #1;
        chk("stat_good", st_good[s] & cm, sat(s, e_good[s]));
        chk("stat_drop", st_drop[s] & cm, sat(s, e_drop[s]));
        chk("stat_filtered", st_filt[s] & cm, sat(s, e_filt[s]));
        chk("early_pulses", n_early[s], e_early_n[s]);
        chk("invalid_pulses", n_inv[s], e_inv_n[s]);
    endtask

    task automatic reset_check(input int s);
        chk("rst_hdr_ready", hdr_ready[s], 0);
        chk("rst_tready", tready[s], 0);
        chk("rst_busy", busy[s], 0);
        chk("rst_m_valid", mvalid[s], 0);
        chk("rst_err_early", e_early[s], 0);
        chk("rst_err_invalid", e_inv[s], 0);
        chk("rst_stats", {st_good[s][1:0], st_drop[s][1:0], st_filt[s][1:0]}, 0);
    endtask

    task automatic rand_frame(input int s);
        int mut;
        default_frame();
        f_smac = {16'($urandom), $urandom};
        f_sha  = {16'($urandom), $urandom};
        f_tha  = {16'($urandom), $urandom};
        f_spa  = $urandom;
        f_oper = 16'($urandom_range(1, 2));
        f_len  = $urandom_range(28, (s == 0) ? 60 : 64);
        mut    = $urandom_range(0, 9);
        case (mut)
            0: f_len   = $urandom_range(5, 27);
            1: f_hlen  = 8'($urandom_range(7, 255));
            2: f_ptype = 16'h86DD;
            3: f_user  = 1'b1;
            4: f_oper  = 16'd3;
            5: f_etype = 16'h0800;
            6: f_tpa   = $urandom;
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            hdr_valid[s] = 0; dmac[s] = 0; smac[s] = 0; etype[s] = 0; tdata[s] = 0; tkeep[s] = 0;
            tvalid[s] = 0; tlast[s] = 0; tuser[s] = 0; mready[s] = 0;
            e_good[s] = 0; e_drop[s] = 0; e_filt[s] = 0; e_early_n[s] = 0; e_inv_n[s] = 0;
        end
        lip[0] = 32'hC0A8_0166;
        lip[1] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_check(0);
        reset_check(1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("hdr_ready_after_reset0", hdr_ready[0], 1);
        chk("hdr_ready_after_reset1", hdr_ready[1], 1);

        // 8-bit: reference request frame
        default_frame();
        send_frame(0, 0);
        drain(0);
        check_stats(0);

        // truncated, bad hlen, bad ptype, tuser, reply with padding
        default_frame(); f_len = 20;        send_frame(0, 0); check_stats(0);
        default_frame(); f_hlen = 8'd8;     send_frame(0, 0); check_stats(0);
        default_frame(); f_ptype = 16'h86DD; send_frame(0, 0); check_stats(0);
        default_frame(); f_user = 1'b1;     send_frame(0, 0); check_stats(0);
        default_frame(); f_oper = 16'd2; f_len = 42; send_frame(0, 0); drain(0); check_stats(0);

        for (int i = 0; i < 12; i++) begin
            rand_frame(0);
            send_frame(0, 0);
            drain(0);
        end
        check_stats(0);

        // queue full: four frames fill it, header ready must fall
        for (int i = 0; i < 4; i++) begin rand_frame(0); f_len = 28 + i; f_hlen = 8'd6; f_ptype = 16'h0800;
            f_etype = 16'h0806; f_oper = 16'd1; f_user = 1'b0; f_tpa = lip[0]; send_frame(0, 0); end
        repeat (3) @(posedge clk);
        #1;
        chk("hdr_ready_when_full", hdr_ready[0], 0);
        chk("valid_when_full", mvalid[0], 1);
        pop_check(0);
        default_frame(); f_sha = 48'h0000_0000_0005; send_frame(0, 0);
        pop_check(0);
        default_frame(); f_sha = 48'h0000_0000_0006; send_frame(0, 0);
        drain(0);
        check_stats(0);

        // target-IP filter
        lip[0] = 32'h0A00_0001;
        default_frame(); f_tpa = 32'h0A00_0002; send_frame(0, 0);
        default_frame(); f_tpa = 32'h0A00_0001; send_frame(0, 0);
        drain(0);
        check_stats(0);
        lip[0] = 32'hC0A8_0166;

        // 64-bit: padded frame with partial last beat, truncation, saturation
        default_frame(); f_len = 46; send_frame(1, 0); drain(1); check_stats(1);
        default_frame(); f_len = 20; send_frame(1, 0); check_stats(1);
        default_frame(); f_len = 28; send_frame(1, 0); drain(1);
        for (int i = 0; i < 10; i++) begin
            rand_frame(1);
            send_frame(1, 0);
            drain(1);
        end
        for (int i = 0; i < 3; i++) begin default_frame(); f_len = 29 + i; send_frame(1, 0); drain(1); end
        check_stats(1);

        // reset in the middle of ARP collection
        default_frame();
        send_frame(0, 10);
        chk("busy_mid_frame", busy[0], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_check(0);
        reset_check(1);
        for (int s = 0; s < 2; s++) begin e_good[s] = 0; e_drop[s] = 0; e_filt[s] = 0; end
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("hdr_ready_after_midreset", hdr_ready[0], 1);
        default_frame(); f_spa = 32'hC0A8_0107; send_frame(0, 0);
        drain(0);
        check_stats(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
